// File: rtl/exc_defs.sv
// exc_defs: event codes, exception vector, CP0 bit indices and FSM states for exc_ctrl.
package exc_defs;
  localparam logic [31:0] EXC_NONE = 32'h0;
  localparam logic [31:0] EXC_INT  = 32'h1;
  localparam logic [31:0] EXC_ADEL = 32'h4;
  localparam logic [31:0] EXC_ADES = 32'h5;
  localparam logic [31:0] EXC_SYS  = 32'h8;
  localparam logic [31:0] EXC_BP   = 32'h9;
  localparam logic [31:0] EXC_RI   = 32'hA;
  localparam logic [31:0] EXC_OV   = 32'hC;
  localparam logic [31:0] EXC_ERET = 32'hE;
  localparam logic [31:0] EXC_VECTOR_DEF = 32'hBFC00380;
  localparam int ST_IE    = 0;
  localparam int ST_EXL   = 1;
  localparam int ST_IM_LO = 8;
  localparam int ST_IM_HI = 15;
  localparam int CA_IP_LO = 8;
  localparam int CNT_W    = 2;
  typedef enum logic {S_IDLE, S_FLUSH} exc_state_t;
endpackage

// File: rtl/int_sync.sv
// int_sync: two-flop synchronizer for the hardware interrupt lines.
module int_sync #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] m;
  always_ff @(posedge clk)
    if (rst) {q, m} <= '0;
    else {q, m} <= {m, d};
endmodule

// File: rtl/exc_ctrl.sv
// exc_ctrl: MEM-stage exception/interrupt decision, flush and redirect; EXC_TIMER_INT_EN ORs timer_int_i into line 5.
module exc_ctrl import exc_defs::*; #(
  parameter int          FLUSH_CYCLES = 1,
  parameter logic [31:0] EXC_VECTOR   = EXC_VECTOR_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        valid_i,
  input  logic [31:0] pc_i,
  input  logic        in_delayslot_i,
  input  logic        adel_if_i,
  input  logic        ri_i,
  input  logic        ov_i,
  input  logic        syscall_i,
  input  logic        break_i,
  input  logic        adel_mem_i,
  input  logic        ades_mem_i,
  input  logic        eret_i,
  input  logic [31:0] mem_addr_i,
  input  logic [5:0]  hw_int_i,
  input  logic        timer_int_i,
  input  logic [31:0] status_i,
  input  logic [31:0] cause_i,
  input  logic [31:0] epc_i,
  output logic [31:0] excepttype_o,
  output logic [5:0]  cp0_int_o,
  output logic [31:0] pc_o,
  output logic        in_delayslot_o,
  output logic [31:0] bad_addr_o,
  output logic        flush_o,
  output logic [31:0] newpc_o
);
  exc_state_t       state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [31:0]      tgt, code, target;
  logic [5:0]       int_raw, int_q;
  logic             int_pend, take, busy, unused_bits;
`ifdef EXC_TIMER_INT_EN
  assign int_raw = {hw_int_i[5] | timer_int_i, hw_int_i[4:0]};
  assign unused_bits = ^{status_i[31:16], status_i[7:2], cause_i[31:10], cause_i[7:0]};
`else
  assign int_raw = hw_int_i;
  assign unused_bits = ^{timer_int_i, status_i[31:16], status_i[7:2], cause_i[31:10], cause_i[7:0]};
`endif
  int_sync #(.W(6)) u_sync (.clk(clk), .rst(rst), .d(int_raw), .q(int_q));
  assign int_pend = status_i[ST_IE] & ~status_i[ST_EXL] &
                    |({int_q, cause_i[CA_IP_LO+1:CA_IP_LO]} & status_i[ST_IM_HI:ST_IM_LO]);
  always_comb
    code = int_pend   ? EXC_INT  :
           adel_if_i  ? EXC_ADEL :
           ri_i       ? EXC_RI   :
           ov_i       ? EXC_OV   :
           syscall_i  ? EXC_SYS  :
           break_i    ? EXC_BP   :
           adel_mem_i ? EXC_ADEL :
           ades_mem_i ? EXC_ADES :
           eret_i     ? EXC_ERET : EXC_NONE;
  assign take   = ~rst & valid_i & ~stall_i & (state == S_IDLE) & (code != EXC_NONE);
  assign busy   = ~rst & (state == S_FLUSH);
  assign target = (code == EXC_ERET) ? epc_i : EXC_VECTOR;
  always_ff @(posedge clk)
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      tgt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (take) tgt <= target;
    end
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    if (take && FLUSH_CYCLES > 1) begin
      state_n = S_FLUSH;
      cnt_n   = CNT_W'(FLUSH_CYCLES - 1);
    end else if (state == S_FLUSH) begin
      cnt_n   = cnt - 1'b1;
      state_n = (cnt == CNT_W'(1)) ? S_IDLE : S_FLUSH;
    end
  end
  // An AdEL/AdES winner with adel_if_i set must be the fetch fault, since it outranks the data faults.
  assign bad_addr_o     = (take && (code == EXC_ADEL || code == EXC_ADES)) ? (adel_if_i ? pc_i : mem_addr_i) : '0;
  assign excepttype_o   = take ? code : EXC_NONE;
  assign cp0_int_o      = rst ? '0 : int_q;
  assign pc_o           = rst ? '0 : pc_i;
  assign in_delayslot_o = ~rst & in_delayslot_i;
  assign flush_o        = take | busy;
  assign newpc_o        = take ? target : busy ? tgt : '0;
endmodule

// File: tb/tb_exc_ctrl.sv
// tb_exc_ctrl: scoreboard bench running FLUSH_CYCLES=1 and =3 instances against a behavioural model.
module tb_exc_ctrl;
  typedef struct {
    logic [31:0] et;
    logic [5:0]  ci;
    logic [31:0] pc;
    logic        ds;
    logic [31:0] bad;
    logic        fl;
    logic [31:0] np;
  } rec_t;

  logic clk = 0, rst = 1;
  logic stall, valid, ds, adel_if, ri, ov, sys, brk, adel_mem, ades_mem, eret, timer;
  logic [31:0] pc, mem_addr, status, cause, epc;
  logic [5:0] hw;
  logic [31:0] et1, pc1, bad1, np1, et3, pc3, bad3, np3;
  logic [5:0] ci1, ci3;
  logic ds1, fl1, ds3, fl3;

  rec_t sb0[$], sb1[$];
  int checks = 0, passed = 0;
  int busy[2] = '{0, 0};
  int fcs[2] = '{1, 3};
  logic [31:0] tgt[2];
  logic [5:0] d1 = 0, d2 = 0;

  always #5 clk = ~clk;

  exc_ctrl #(.FLUSH_CYCLES(1)) u1 (
    .clk(clk), .rst(rst), .stall_i(stall), .valid_i(valid), .pc_i(pc), .in_delayslot_i(ds),
    .adel_if_i(adel_if), .ri_i(ri), .ov_i(ov), .syscall_i(sys), .break_i(brk),
    .adel_mem_i(adel_mem), .ades_mem_i(ades_mem), .eret_i(eret), .mem_addr_i(mem_addr),
    .hw_int_i(hw), .timer_int_i(timer), .status_i(status), .cause_i(cause), .epc_i(epc),
    .excepttype_o(et1), .cp0_int_o(ci1), .pc_o(pc1), .in_delayslot_o(ds1),
    .bad_addr_o(bad1), .flush_o(fl1), .newpc_o(np1));

  exc_ctrl #(.FLUSH_CYCLES(3)) u3 (
    .clk(clk), .rst(rst), .stall_i(stall), .valid_i(valid), .pc_i(pc), .in_delayslot_i(ds),
    .adel_if_i(adel_if), .ri_i(ri), .ov_i(ov), .syscall_i(sys), .break_i(brk),
    .adel_mem_i(adel_mem), .ades_mem_i(ades_mem), .eret_i(eret), .mem_addr_i(mem_addr),
    .hw_int_i(hw), .timer_int_i(timer), .status_i(status), .cause_i(cause), .epc_i(epc),
    .excepttype_o(et3), .cp0_int_o(ci3), .pc_o(pc3), .in_delayslot_o(ds3),
    .bad_addr_o(bad3), .flush_o(fl3), .newpc_o(np3));

  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", n, got, exp, $time);
  endtask

  always @(negedge clk)
    if (sb0.size() > 0 && sb1.size() > 0) begin
      rec_t a, b;
      a = sb0.pop_front();
      b = sb1.pop_front();
      chk("u1.excepttype", et1, a.et);
      chk("u1.cp0_int", {26'd0, ci1}, {26'd0, a.ci});
      chk("u1.pc", pc1, a.pc);
      chk("u1.delayslot", {31'd0, ds1}, {31'd0, a.ds});
      chk("u1.bad_addr", bad1, a.bad);
      chk("u1.flush", {31'd0, fl1}, {31'd0, a.fl});
      chk("u1.newpc", np1, a.np);
      chk("u3.excepttype", et3, b.et);
      chk("u3.cp0_int", {26'd0, ci3}, {26'd0, b.ci});
      chk("u3.pc", pc3, b.pc);
      chk("u3.delayslot", {31'd0, ds3}, {31'd0, b.ds});
      chk("u3.bad_addr", bad3, b.bad);
      chk("u3.flush", {31'd0, fl3}, {31'd0, b.fl});
      chk("u3.newpc", np3, b.np);
    end

  // One cycle: derive expectations from the current inputs, queue them, then advance the model.
  task automatic step();
    logic [31:0] codes[9] = '{32'h1, 32'h4, 32'hA, 32'hC, 32'h8, 32'h9, 32'h4, 32'h5, 32'hE};
    logic [8:0] f;
    logic ip;
    int win;
    rec_t e;
    ip = status[0] && !status[1] && (({d2, cause[9:8]} & status[15:8]) != 0);
    f = {eret, ades_mem, adel_mem, brk, sys, ov, ri, adel_if, ip};
    win = -1;
    for (int i = 8; i >= 0; i--) if (f[i]) win = i;
    for (int k = 0; k < 2; k++) begin
      e = '{et: 0, ci: 0, pc: 0, ds: 0, bad: 0, fl: 0, np: 0};
      if (rst) busy[k] = 0;
      else begin
        e.ci = d2;
        e.pc = pc;
        e.ds = ds;
        if (busy[k] > 0) begin
          e.fl = 1;
          e.np = tgt[k];
          busy[k]--;
        end else if (valid && !stall && win >= 0) begin
          e.et  = codes[win];
          e.bad = (win == 1) ? pc : (win == 6 || win == 7) ? mem_addr : 0;
          e.fl  = 1;
          e.np  = (win == 8) ? epc : 32'hBFC00380;
          tgt[k]  = e.np;
          busy[k] = fcs[k] - 1;
        end
      end
      if (k == 0) sb0.push_back(e);
      else sb1.push_back(e);
    end
    if (rst) begin
      d2 = 0;
      d1 = 0;
    end else begin
      d2 = d1;
`ifdef EXC_TIMER_INT_EN
      d1 = hw | {timer, 5'd0};
`else
      d1 = hw;
`endif
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    {adel_if, ri, ov, sys, brk, adel_mem, ades_mem, eret, timer, stall, ds} = '0;
    valid = 1;
    hw = 0;
    status = 0;
    cause = 0;
    pc = $urandom;
    mem_addr = $urandom;
    epc = $urandom;
  endtask

  initial begin
    clr();
    rst = 1;
    @(posedge clk);
    #1;
    repeat (3) step();
    rst = 0;
    clr();
    step();
    pc = 32'h80000010; sys = 1; step();
    sys = 0; repeat (3) step();
    mem_addr = 32'h80001002; adel_mem = 1; ri = 1; step();
    adel_mem = 0; ri = 0; repeat (3) step();
    status = 32'h00001001; hw = 6'b000100; repeat (4) step();
    hw = 0; repeat (4) step();
    status = 32'h00001003; hw = 6'b000100; repeat (4) step();
    hw = 0; repeat (3) step();
    status = 0; epc = 32'h80000044; eret = 1; step();
    eret = 0; repeat (3) step();
    brk = 1; step();
    brk = 0; ov = 1; step();
    ov = 0; repeat (3) step();
    ov = 1; stall = 1; step(); step();
    stall = 0; step();
    ov = 0; repeat (3) step();
    brk = 1; step();
    brk = 0; rst = 1; step();
    rst = 0; repeat (3) step();
    status = 32'h0000FF01; eret = 1; hw = 6'b000001; repeat (3) step();
    eret = 0; hw = 0; repeat (3) step();
    for (int n = 0; n < 1500; n++) begin
      rst = ($urandom_range(63) == 0);
      stall = ($urandom_range(3) == 0);
      valid = ($urandom_range(3) != 0);
      ds = $urandom_range(1);
      pc = $urandom;
      mem_addr = $urandom;
      epc = $urandom;
      cause = $urandom;
      status = $urandom;
      status[0] = ($urandom_range(3) != 0);
      status[1] = ($urandom_range(3) == 0);
      hw = ($urandom_range(3) == 0) ? 6'($urandom) : 6'd0;
      timer = ($urandom_range(7) == 0);
      adel_if = ($urandom_range(15) == 0);
      ri = ($urandom_range(15) == 0);
      ov = ($urandom_range(15) == 0);
      sys = ($urandom_range(15) == 0);
      brk = ($urandom_range(15) == 0);
      adel_mem = ($urandom_range(15) == 0);
      ades_mem = ($urandom_range(15) == 0);
      eret = ($urandom_range(15) == 0);
      step();
    end
    @(negedge clk);
    #1;
    chk("scoreboard_drain", sb0.size() + sb1.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/exc_ctrl.md
# exc_ctrl

Exception/interrupt controller in the MEM stage of the MIPS pipeline. It collects per-instruction exception flags, synchronizes the hardware interrupt lines, and checks Status/Cause. It produces the exception-type code, faulting PC, delay-slot flag and bad address that the CP0 register file consumes, plus the pipeline flush and redirect PC. It is the producing end of the CP0 exception interface: CP0 records the event and this block decides it.

## Interface

Parameters:
- FLUSH_CYCLES, 1: cycles flush_o stays high per event (1..4).
- EXC_VECTOR, 32'hBFC00380: redirect target for every exception except ERET.

Ports:
- clk  in  1  core clock.
- rst  in  1  reset; synchronous, active-high.
- stall_i  in  1  MEM stage stalled; no event is taken while high.
- valid_i  in  1  MEM holds a real instruction (not a bubble).
- pc_i  in  32  PC of the MEM instruction.
- in_delayslot_i  in  1  MEM instruction is in a delay slot.
- adel_if_i, ri_i, ov_i, syscall_i, break_i, adel_mem_i, ades_mem_i, eret_i  in  1 each  per-instruction exception flags.
- mem_addr_i  in  32  data access address.
- hw_int_i  in  6  asynchronous hardware interrupt lines.
- timer_int_i  in  1  CP0 timer interrupt (used only with EXC_TIMER_INT_EN).
- status_i, cause_i, epc_i  in  32 each  current CP0 values; epc_i already forwarded.
- excepttype_o  out  32  event code to CP0; 0 = none.
- cp0_int_o  out  6  synchronized interrupt lines to CP0 Cause[15:10].
- pc_o  out  32  faulting PC (equals pc_i).
- in_delayslot_o  out  1  equals in_delayslot_i.
- bad_addr_o  out  32  bad virtual address.
- flush_o  out  1  flush IF..MEM.
- newpc_o  out  32  redirect PC, valid while flush_o is high.

## Operation

- Event codes: 1 interrupt, 4 AdEL, 5 AdES, 8 Syscall, 9 Break, A RI, C Ov, E ERET.
- Interrupt pending: Status[0]=1 and Status[1]=0 and ({cp0_int_o, cause_i[9:8]} & status_i[15:8]) != 0.
- Priority, highest first: interrupt, adel_if, ri, ov, syscall, break, adel_mem, ades_mem, eret.
- Only the highest-priority event is encoded.
- Events are taken only when valid_i=1, stall_i=0 and state is IDLE. Otherwise excepttype_o is 0.
- bad_addr_o is pc_i for adel_if, mem_addr_i for adel_mem or ades_mem, and 0 otherwise.
- newpc_o is epc_i for ERET and EXC_VECTOR for all other events.
- FSM states:
  - IDLE: on a taken event, go to FLUSH with cnt = FLUSH_CYCLES-1. If FLUSH_CYCLES=1, stay in IDLE instead.
  - FLUSH: flush_o=1, newpc_o holds the registered target, new events are masked. cnt decrements each cycle; go to IDLE when cnt=0.
- The interrupt synchronizer is two flops per line, reset to 0.

## Timing

- excepttype_o, pc_o, bad_addr_o, flush_o and newpc_o are combinational in the detection cycle T. CP0 samples them on the negedge inside T.
- flush_o is high in T and in the following FLUSH_CYCLES-1 cycles. The target is registered at the end of T.
- hw_int_i to cp0_int_o latency is 2 clock edges.
- A stall arriving in the detection cycle defers the event. The flags are re-evaluated once stall_i falls.
- A simultaneous eret_i and interrupt produces the interrupt (code 1), and newpc_o is EXC_VECTOR.
- Reset values: state IDLE, cnt 0, sync flops 0. All outputs are 0 while rst=1, including flush_o and newpc_o.
- Reset asserted mid-FLUSH returns to IDLE at that edge. flush_o is 0 from then on.

## Configuration

- EXC_TIMER_INT_EN
  - Defined: cp0_int_o[5] is the synchronized (hw_int_i[5] | timer_int_i).
  - Undefined: timer_int_i is ignored and cp0_int_o[5] is the synchronized hw_int_i[5].

## Structure

- Shared package exc_defs holds the event-code constants (EXC_INT ... EXC_ERET), the EXC_VECTOR default, the Status/Cause bit-index constants and the FSM state enum.
- One sub-module, int_sync: a 6-bit two-flop synchronizer with synchronous reset.

## Test plan

- Syscall at pc_i=0x80000010, not in a delay slot -> excepttype_o=8, pc_o=0x80000010, flush_o=1 for one cycle, newpc_o=0xBFC00380.
- adel_mem_i with mem_addr_i=0x80001002 and ri_i both set -> excepttype_o=0xA (RI wins), bad_addr_o=0.
- hw_int_i[2]=1, status_i=0x0000_1001 -> excepttype_o=1 exactly two cycles later at the first valid, unstalled instruction. With status_i[1]=1, there is no event.
- eret_i with epc_i=0x80000044 -> excepttype_o=0xE, newpc_o=0x80000044.
- FLUSH_CYCLES=3, break_i then ov_i on the next cycle -> one event (code 9), flush_o high for 3 cycles, ov_i masked.
- stall_i held for 2 cycles with ov_i set -> excepttype_o=0 while stalled and =0xC in the first unstalled cycle. rst pulsed during FLUSH -> flush_o=0 next cycle.
